fp_argmax_stream: RTL
=====================

// Module: fp_argmax_stream
// PURPOSE
//   Streaming IEEE-754 single-precision max/argmax unit. Accepts a frame of
//   NUM_ITEMS float32 scores, one per valid/ready beat, and returns the largest
//   value together with its index within the frame. Sits after the classifier
//   output layer, replacing pairwise combinational max trees for class selection.
// PARAMETERS
//   DATA_WIDTH  32  operand width; float32 layout fixed (1 sign, 8 exp, 23 mantissa)
//   NUM_ITEMS   8   items per frame, >= 2; IDX_W = $clog2(NUM_ITEMS) (localparam)
// PORTS
//   clk        in   1           single clock, all logic on rising edge
//   rst_n      in   1           synchronous reset, active low
//   in_valid   in   1           input beat valid
//   in_ready   out  1           unit can accept a beat
//   in_data    in   DATA_WIDTH  float32 score
//   out_valid  out  1           result valid
//   out_ready  in   1           consumer accepts result
//   out_max    out  DATA_WIDTH  largest non-NaN score of the frame
//   out_index  out  IDX_W       0-based frame position of out_max
//   out_nan    out  1           at least one NaN seen in the frame
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (rst_n sampled on clk).
//   - Reset: state=ACCUM, count=0, in_ready=1, out_valid=0, out_max=0,
//     out_index=0, out_nan=0, running max/index/nan/seen flags cleared.
//   - FSM ACCUM: in_ready=1. Beat accepted when in_valid&in_ready; count++ only
//     on acceptance (gaps in in_valid are allowed). Beat at count==NUM_ITEMS-1
//     is last: results registered, count->0, state->HOLD.
//   - FSM HOLD: in_ready=0, out_valid=1, outputs stable until out_ready=1;
//     on that edge out_valid->0, running state cleared, state->ACCUM.
//   - Latency: out_valid rises the cycle after the last beat is accepted.
//     Throughput: one frame per NUM_ITEMS+1 cycles with no stalls.
//   - Comparison (combinational, registered result): candidate replaces the
//     running max only if strictly greater. Order: +x > -y; both positive ->
//     larger {exp,mant} wins; both negative -> smaller {exp,mant} wins;
//     +0 == -0; +/-Inf ordered normally; denormals compared by bits.
//   - Tie: earlier index kept (lowest index wins).
//   - NaN (exp=8'hFF, mant!=0): never becomes max; sets sticky nan flag.
//   - First non-NaN beat of a frame always loads the running max and index.
//   - All beats NaN: out_max=32'h7FC00000, out_index=0, out_nan=1.
//   - rst_n low mid-frame or in HOLD: partial frame discarded; next accepted
//     beat is item 0 of a fresh frame.
// TESTING
//   1. Frame {0,1.0,2.0,0.5,-1.0,0x404A1ADF,3.0,0} -> out_max 0x404A1ADF,
//      out_index 5, out_nan 0, out_valid high exactly 1 cycle after beat 7.
//   2. All negative, -0.5 (0xBF000000) at idx 2, rest <= -1.0 (0xBF800000,
//      0xC0800000) -> out_max 0xBF000000, out_index 2.
//   3. -0 (0x80000000) at idx 0, +0 at idx 1, rest negative -> out_max
//      0x80000000, out_index 0 (tie keeps first); duplicate 4.0 at idx 3,6 -> idx 3.
//   4. NaN 0x7FC00001 at idx 3, 1.0 elsewhere, 0x40800000 at idx 6 -> out_max
//      0x40800000, out_index 6, out_nan 1; all-NaN frame -> 0x7FC00000, idx 0, nan 1.
//   5. out_ready low 5 cycles in HOLD -> outputs stable, in_ready 0; raise
//      out_ready -> out_valid 0 next cycle, in_ready 1; in_valid gaps ignored.
//   6. rst_n low 1 cycle after 4 beats -> all outputs at reset values; next 8
//      beats form a new frame with correct max/index.

Source files
------------

// File: rtl/fp_argmax_stream.sv
// Streaming float32 max/argmax unit: one score per beat, one result per frame.
// NaN scores are skipped for the max but raise a sticky flag for the frame.
module fp_argmax_stream #(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_ITEMS  = 8,
   localparam int IDX_W      = $clog2(NUM_ITEMS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_max,
   output logic [IDX_W-1:0]      out_index,
   output logic                  out_nan
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CANON_NAN = 32'h7FC00000;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_ITEMS - 1);

   state_t                state;
   logic [IDX_W-1:0]      count;
   logic [DATA_WIDTH-1:0] run_max;
   logic [IDX_W-1:0]      run_idx;
   logic                  run_nan;
   logic                  run_seen;

   logic                  beat;
   logic                  cand_nan;
   logic                  cand_take;
   logic [DATA_WIDTH-1:0] nxt_max;
   logic [IDX_W-1:0]      nxt_idx;
   logic                  nxt_nan;
   logic                  nxt_seen;

   // Strict IEEE ordering of two non-NaN floats; +0 and -0 compare equal so a
   // later zero of the other sign never displaces an earlier one.
   function automatic logic is_greater(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
      logic a_zero;
      logic b_zero;
      logic res;
      a_zero = (a[DATA_WIDTH-2:0] == '0);
      b_zero = (b[DATA_WIDTH-2:0] == '0);
      if (a_zero && b_zero)
         res = 1'b0;
      else if (!a[DATA_WIDTH-1] && b[DATA_WIDTH-1])
         res = 1'b1;
      else if (a[DATA_WIDTH-1] && !b[DATA_WIDTH-1])
         res = 1'b0;
      else if (!a[DATA_WIDTH-1])
         res = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]);
      else
         res = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]);
      return res;
   endfunction

   // Fold the incoming beat into the running max/index/nan state.
   always_comb begin
      beat      = in_valid && in_ready;
      cand_nan  = (in_data[DATA_WIDTH-2:DATA_WIDTH-9] == 8'hFF) &&
                  (in_data[DATA_WIDTH-10:0] != '0);
      cand_take = !cand_nan && (!run_seen || is_greater(in_data, run_max));
      nxt_max   = cand_take ? in_data : run_max;
      nxt_idx   = cand_take ? count : run_idx;
      nxt_nan   = run_nan || cand_nan;
      nxt_seen  = run_seen || !cand_nan;
   end

   // Frame FSM: accumulate beats, then hold the registered result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACCUM;
         count     <= '0;
         run_max   <= '0;
         run_idx   <= '0;
         run_nan   <= 1'b0;
         run_seen  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_max   <= '0;
         out_index <= '0;
         out_nan   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (beat) begin
                  run_max  <= nxt_max;
                  run_idx  <= nxt_idx;
                  run_nan  <= nxt_nan;
                  run_seen <= nxt_seen;
                  if (count == LAST_IDX) begin
                     count     <= '0;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_max   <= nxt_seen ? nxt_max : CANON_NAN;
                     out_index <= nxt_seen ? nxt_idx : '0;
                     out_nan   <= nxt_nan;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  run_max   <= '0;
                  run_idx   <= '0;
                  run_nan   <= 1'b0;
                  run_seen  <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
